// File: rtl/fetch_align_decomp_if.sv
// Fetch-side and decode-side handshake bundle for the fetch aligner.
// master = aligner, slave = memory/decode environment.
interface fetch_align_decomp_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_compr;
    logic        inst_illegal;

    modport master (
        input  redirect, redirect_pc, fetch_valid, fetch_data, inst_ready,
        output fetch_req, fetch_addr, inst_valid, inst_out, inst_pc, inst_compr, inst_illegal
    );

    modport slave (
        output redirect, redirect_pc, fetch_valid, fetch_data, inst_ready,
        input  fetch_req, fetch_addr, inst_valid, inst_out, inst_pc, inst_compr, inst_illegal
    );
endinterface

// File: rtl/fetch_align_decomp.sv
// Fetch aligner + RV32C expander: halfword queue feeding a one-entry output register.
// Latency: fetch accepted in cycle N presents an instruction no earlier than N+2.
// Backpressure: Inst_* hold while stalled; fetch stops once fewer than 2 slots are free.
module fetch_align_decomp #(
    parameter int unsigned DEPTH_HW = 4,
    parameter bit          C_EXT    = 1'b1,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_align_decomp_if.master bus
);
    localparam int unsigned AW        = $clog2(DEPTH_HW);
    localparam int unsigned CW        = AW + 1;
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [CW-1:0] FETCH_MAX = CW'(DEPTH_HW - 2);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] TWO     = CW'(2);

    logic [15:0]   hbuf [DEPTH_HW];
    logic [AW-1:0] head, tail, head_p1, tail_p1;
    logic [CW-1:0] count;
    logic [31:0]   pc, fetch_addr;
    logic          skip_lo;
    logic          inst_valid, inst_compr, inst_illegal;
    logic [31:0]   inst_out, inst_pc;

    logic          fetch_req, accept, load, is32, complete;
    logic [1:0]    push_n, pop_n;
    logic [15:0]   h0, h1;
    logic [32:0]   dec;

    // Pass-through check for 32-bit encodings; returns {illegal, instruction}.
    function automatic logic [32:0] dec32(input logic [31:0] i);
        case (i[6:2])
            5'b00000, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011: dec32 = {1'b0, i};
            default:                                dec32 = {1'b1, NOP};
        endcase
    endfunction

    function automatic logic [32:0] expand16(input logic [15:0] c);
        logic [4:0]  rdp, rs2p, rd, rs2;
        logic [11:0] imm6, lwoff;
        logic [5:0]  shamt;
        logic [20:1] joff;
        logic [12:1] boff;
        logic [31:0] r;
        logic        ill;
        rdp   = {2'b01, c[9:7]};
        rs2p  = {2'b01, c[4:2]};
        rd    = c[11:7];
        rs2   = c[6:2];
        imm6  = {{6{c[12]}}, c[12], c[6:2]};
        shamt = {c[12], c[6:2]};
        lwoff = {5'b0, c[5], c[12:10], c[6], 2'b00};
        joff  = {{9{c[12]}}, c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3]};
        boff  = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3]};
        r     = NOP;
        ill   = 1'b0;
        case ({c[1:0], c[15:13]})
            5'b00_010: r = {lwoff, rdp, 3'b010, rs2p, 7'b0000011};
            5'b00_110: r = {lwoff[11:5], rs2p, rdp, 3'b010, lwoff[4:0], 7'b0100011};
            5'b01_000: r = {imm6, rd, 3'b000, rd, 7'b0010011};
            5'b01_001: r = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd1, 7'b1101111};
            5'b01_010: r = {imm6, 5'd0, 3'b000, rd, 7'b0010011};
            5'b01_011: begin
                // rd=x2 is C.ADDI16SP, not supported here
                if (rd == 5'd2 || shamt == 6'd0) ill = 1'b1;
                else r = {{14{c[12]}}, c[12], c[6:2], rd, 7'b0110111};
            end
            5'b01_100: begin
                case (c[11:10])
                    2'b00: if (c[12]) ill = 1'b1;
                           else r = {7'b0000000, shamt[4:0], rdp, 3'b101, rdp, 7'b0010011};
                    2'b01: if (c[12]) ill = 1'b1;
                           else r = {7'b0100000, shamt[4:0], rdp, 3'b101, rdp, 7'b0010011};
                    2'b10: r = {imm6, rdp, 3'b111, rdp, 7'b0010011};
                    default: begin
                        if (c[12]) ill = 1'b1;
                        else begin
                            case (c[6:5])
                                2'b00:   r = {7'b0100000, rs2p, rdp, 3'b000, rdp, 7'b0110011};
                                2'b01:   r = {7'b0000000, rs2p, rdp, 3'b100, rdp, 7'b0110011};
                                2'b10:   r = {7'b0000000, rs2p, rdp, 3'b110, rdp, 7'b0110011};
                                default: r = {7'b0000000, rs2p, rdp, 3'b111, rdp, 7'b0110011};
                            endcase
                        end
                    end
                endcase
            end
            5'b01_101: r = {joff[20], joff[10:1], joff[11], joff[19:12], 5'd0, 7'b1101111};
            5'b01_110: r = {boff[12], boff[10:5], 5'd0, rdp, 3'b000, boff[4:1], boff[11], 7'b1100011};
            5'b01_111: r = {boff[12], boff[10:5], 5'd0, rdp, 3'b001, boff[4:1], boff[11], 7'b1100011};
            5'b10_000: if (c[12]) ill = 1'b1;
                       else r = {7'b0000000, shamt[4:0], rd, 3'b001, rd, 7'b0010011};
            5'b10_100: begin
                if (rs2 == 5'd0) begin
                    // rd=x0 is reserved (JR) or EBREAK (JALR), neither supported
                    if (rd == 5'd0) ill = 1'b1;
                    else r = {12'd0, rd, 3'b000, 4'd0, c[12], 7'b1100111};
                end else if (!c[12]) begin
                    r = {7'b0000000, rs2, 5'd0, 3'b000, rd, 7'b0110011};
                end else begin
                    r = {7'b0000000, rs2, rd, 3'b000, rd, 7'b0110011};
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) r = NOP;
        expand16 = {ill, r};
    endfunction

    assign head_p1   = head + AW'(1);
    assign tail_p1   = tail + AW'(1);
    assign fetch_req = !bus.redirect && (count <= FETCH_MAX);
    assign accept    = fetch_req && bus.fetch_valid;
    assign push_n    = !accept ? 2'd0 : (skip_lo ? 2'd1 : 2'd2);

    always_comb begin
        h0       = hbuf[head];
        h1       = hbuf[head_p1];
        is32     = (h0[1:0] == 2'b11);
        complete = is32 ? (count >= TWO) : (count >= ONE);
        if (is32)       dec = dec32({h1, h0});
        else if (C_EXT) dec = expand16(h0);
        else            dec = {1'b1, NOP};
    end

    assign load  = complete && (!inst_valid || bus.inst_ready) && !bus.redirect;
    assign pop_n = !load ? 2'd0 : (is32 ? 2'd2 : 2'd1);

    // Storage carries no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (skip_lo) begin
                hbuf[tail] <= bus.fetch_data[31:16];
            end else begin
                hbuf[tail]    <= bus.fetch_data[15:0];
                hbuf[tail_p1] <= bus.fetch_data[31:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            pc           <= RESET_PC & ~32'h1;
            fetch_addr   <= RESET_PC & ~32'h3;
            skip_lo      <= RESET_PC[1];
            inst_valid   <= 1'b0;
            inst_out     <= NOP;
            inst_pc      <= RESET_PC;
            inst_compr   <= 1'b0;
            inst_illegal <= 1'b0;
        end else if (bus.redirect) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            pc         <= bus.redirect_pc & ~32'h1;
            fetch_addr <= bus.redirect_pc & ~32'h3;
            skip_lo    <= bus.redirect_pc[1];
            inst_valid <= 1'b0;
        end else begin
            if (accept) begin
                fetch_addr <= fetch_addr + 32'd4;
                skip_lo    <= 1'b0;
                tail       <= tail + AW'(push_n);
            end
            head  <= head + AW'(pop_n);
            count <= count + CW'(push_n) - CW'(pop_n);
            if (load) begin
                inst_valid   <= 1'b1;
                inst_out     <= dec[31:0];
                inst_illegal <= dec[32];
                inst_compr   <= !is32;
                inst_pc      <= pc;
                pc           <= pc + (is32 ? 32'd4 : 32'd2);
            end else if (bus.inst_ready) begin
                inst_valid <= 1'b0;
            end
        end
    end

    assign bus.fetch_req    = fetch_req;
    assign bus.fetch_addr   = fetch_addr;
    assign bus.inst_valid   = inst_valid;
    assign bus.inst_out     = inst_out;
    assign bus.inst_pc      = inst_pc;
    assign bus.inst_compr   = inst_compr;
    assign bus.inst_illegal = inst_illegal;
endmodule
